// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause
// field layouts, write masks and the default exception vector.
package cp0_pkg;

    // CP0 register numbers (select 0)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Exception codes delivered by the detection stage
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

    // Status layout: BEV[22], IM[15:8], ERL[2], EXL[1], IE[0]
    typedef struct packed {
        logic [8:0] rsvd_31_23;
        logic       bev;
        logic [5:0] rsvd_21_16;
        logic [7:0] im;
        logic [4:0] rsvd_7_3;
        logic       erl;
        logic       exl;
        logic       ie;
    } status_t;

    // Cause layout: BD[31], TI[30], IP[15:8], ExcCode[6:2]
    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] rsvd_29_16;
        logic [7:0]  ip;
        logic        rsvd_7;
        logic [4:0]  exc_code;
        logic [1:0]  rsvd_1_0;
    } cause_t;

    // Cause.IP[9:8] are the only software-writable Cause bits
    localparam int CAUSE_IP_SW_LO = 8;

    localparam logic [31:0] STATUS_RESET      = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK      = 32'h0000_FF07;
    localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hBFC0_0380;

    // Address-related exceptions are the only ones that latch BadVAddr
    function automatic logic exc_sets_badvaddr(input logic [4:0] code);
        logic sets;
        case (code)
            EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES: sets = 1'b1;
            default:                                         sets = 1'b0;
        endcase
        return sets;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and sticky TI flag.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int               DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic [31:0]      count_r;
    logic [31:0]      compare_r;
    logic             ti_r;
    logic             div_wrap_s;
    logic [31:0]      count_inc_s;
    logic             match_s;

    // Prescaler wrap, next Count value and Compare match on that value
    always_comb begin
        div_wrap_s  = (div_r == DIV_LAST);
        count_inc_s = count_r + 32'd1;
        if (div_wrap_s && !count_we) begin
            match_s = (count_inc_s == compare_r);
        end else begin
            match_s = 1'b0;
        end
    end

    // Prescaler: free-running, restarted by a Count write
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= '0;
        end else if (count_we || div_wrap_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Count: software load takes precedence over the prescaled increment
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 32'd0;
        end else if (count_we) begin
            count_r <= wr_data;
        end else if (div_wrap_s) begin
            count_r <= count_inc_s;
        end
    end

    // Compare register
    always_ff @(posedge clk) begin
        if (reset) begin
            compare_r <= 32'd0;
        end else if (compare_we) begin
            compare_r <= wr_data;
        end
    end

    // TI: set on match, cleared only by a Compare write (which wins)
    always_ff @(posedge clk) begin
        if (reset) begin
            ti_r <= 1'b0;
        end else if (compare_we) begin
            ti_r <= 1'b0;
        end else if (match_s) begin
            ti_r <= 1'b1;
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign ti      = ti_r;

endmodule

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: commits exception records, services
// ERET/MTC0/MFC0, hosts the timer and drives the fetch redirect.
module cp0_regs
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT,
    parameter int          COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        is_eret,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic [5:0]  ext_int,
    output logic [31:0] status,
    output logic [7:0]  interrupt_info,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc
);

    status_t     status_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;
    logic        cause_bd_r;
    logic [4:0]  cause_code_r;
    logic [1:0]  cause_ip_sw_r;
    logic [5:0]  ip_hw_r;

    logic [31:0] count_s;
    logic [31:0] compare_s;
    logic        ti_s;
    logic        wr_commit_s;
    logic        count_we_s;
    logic        compare_we_s;
    logic [7:0]  cause_ip_s;
    cause_t      cause_s;

    // An MTC0 only lands when no exception or ERET claims the same cycle
    always_comb begin
        wr_commit_s  = wr_en && !exc_valid && !is_eret;
        count_we_s   = wr_commit_s && (wr_addr == CP0_COUNT);
        compare_we_s = wr_commit_s && (wr_addr == CP0_COMPARE);
    end

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (count_we_s),
        .compare_we (compare_we_s),
        .wr_data    (wr_data),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // Sample the hardware interrupt lines every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ip_hw_r <= 6'd0;
        end else begin
            ip_hw_r <= ext_int;
        end
    end

    // Status/Cause/EPC/BadVAddr update; exception > ERET > MTC0
    always_ff @(posedge clk) begin
        if (reset) begin
            status_r      <= status_t'(STATUS_RESET);
            epc_r         <= 32'd0;
            badvaddr_r    <= 32'd0;
            cause_bd_r    <= 1'b0;
            cause_code_r  <= 5'd0;
            cause_ip_sw_r <= 2'd0;
        end else if (exc_valid) begin
            // A nested exception keeps the original return point
            if (!status_r.exl) begin
                epc_r      <= exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                cause_bd_r <= exc_in_delay_slot;
            end
            cause_code_r <= exc_code;
            status_r.exl <= 1'b1;
            if (exc_sets_badvaddr(exc_code)) begin
                badvaddr_r <= exc_badvaddr;
            end
        end else if (is_eret) begin
            status_r.exl <= 1'b0;
            status_r.erl <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                CP0_STATUS: status_r <= status_t'((status_r & ~STATUS_WMASK) |
                                                  (wr_data & STATUS_WMASK));
                CP0_CAUSE:  cause_ip_sw_r <= wr_data[CAUSE_IP_SW_LO +: 2];
                CP0_EPC:    epc_r <= wr_data;
                default:    ;
            endcase
        end
    end

    // Assemble Cause; IP7 also carries the timer interrupt
    always_comb begin
        cause_ip_s         = {ip_hw_r[5] | ti_s, ip_hw_r[4:0], cause_ip_sw_r};
        cause_s            = '0;
        cause_s.bd         = cause_bd_r;
        cause_s.ti         = ti_s;
        cause_s.ip         = cause_ip_s;
        cause_s.exc_code   = cause_code_r;
    end

    // MFC0 read mux from current register state
    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            CP0_BADVADDR: rd_data = badvaddr_r;
            CP0_COUNT:    rd_data = count_s;
            CP0_COMPARE:  rd_data = compare_s;
            CP0_STATUS:   rd_data = status_r;
            CP0_CAUSE:    rd_data = cause_s;
            CP0_EPC:      rd_data = epc_r;
            default:      rd_data = 32'd0;
        endcase
    end

    // Fetch redirect for the event committing this cycle
    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = EXC_ENTRY;
        if (reset) begin
            redirect_valid = 1'b0;
            redirect_pc    = EXC_ENTRY;
        end else if (exc_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = EXC_ENTRY;
        end else if (is_eret) begin
            redirect_valid = 1'b1;
            redirect_pc    = epc_r;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = EXC_ENTRY;
        end
    end

    // Feedback to exception detection
    always_comb begin
        status         = status_r;
        epc            = epc_r;
        interrupt_info = cause_ip_s & status_r.im;
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Scoreboard bench for cp0_regs: a behavioural model predicts each cycle's
// outputs, a negedge monitor pops predictions and compares.
module tb_cp0_regs;

    localparam int          DIV   = 2;
    localparam logic [31:0] ENTRY = 32'hBFC0_0380;

    logic        clk;
    logic        reset;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        is_eret;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [5:0]  ext_int;
    logic [31:0] status;
    logic [7:0]  interrupt_info;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] epc;

    cp0_regs #(
        .EXC_ENTRY (ENTRY),
        .COUNT_DIV (DIV)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .exc_valid         (exc_valid),
        .exc_code          (exc_code),
        .exc_pc            (exc_pc),
        .exc_in_delay_slot (exc_in_delay_slot),
        .exc_badvaddr      (exc_badvaddr),
        .is_eret           (is_eret),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .ext_int           (ext_int),
        .status            (status),
        .interrupt_info    (interrupt_info),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .epc               (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra;
        logic [31:0] rd;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] st;
        logic [31:0] ep;
        logic [7:0]  ii;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model (architectural state) ----------------
    logic [31:0] m_epc, m_badv, m_count, m_compare, m_status;
    logic        m_ti, m_bd;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_ext;
    int          m_phase;
    bit          m_known = 1'b0;

    function automatic logic [7:0] m_ip();
        return {m_ext[5] | m_ti, m_ext[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic predict_and_push();
        exp_t e;
        if (m_known) begin
            e.ra = rd_addr;
            e.rd = m_read(rd_addr);
            if (reset)          begin e.rv = 1'b0; e.rpc = ENTRY; end
            else if (exc_valid) begin e.rv = 1'b1; e.rpc = ENTRY; end
            else if (is_eret)   begin e.rv = 1'b1; e.rpc = m_epc; end
            else                begin e.rv = 1'b0; e.rpc = ENTRY; end
            e.st = m_status;
            e.ep = m_epc;
            e.ii = m_ip() & m_status[15:8];
            q.push_back(e);
        end
    endtask

    task automatic model_update();
        bit wr_ok;
        if (reset) begin
            m_known = 1'b1;
            m_epc = 32'd0; m_badv = 32'd0; m_count = 32'd0; m_compare = 32'd0;
            m_status = 32'h0040_0000; m_ti = 1'b0; m_bd = 1'b0; m_code = 5'd0;
            m_ipsw = 2'd0; m_ext = 6'd0; m_phase = 0;
            return;
        end
        m_ext = ext_int;
        wr_ok = wr_en && !exc_valid && !is_eret;
        // timer: one Count tick every DIV cycles unless Count is being loaded
        if (wr_ok && wr_addr == 5'd9) begin
            m_count = wr_data;
            m_phase = 0;
        end else begin
            m_phase = (m_phase + 1) % DIV;
            if (m_phase == 0) begin
                m_count = m_count + 32'd1;
                if (m_count == m_compare) m_ti = 1'b1;
            end
        end
        if (wr_ok && wr_addr == 5'd11) begin
            m_compare = wr_data;
            m_ti = 1'b0;
        end
        if (exc_valid) begin
            if (m_status[1] == 1'b0) begin
                m_epc = exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                m_bd  = exc_in_delay_slot;
            end
            m_code = exc_code;
            m_status[1] = 1'b1;
            if (exc_code >= 5'd1 && exc_code <= 5'd5) m_badv = exc_badvaddr;
        end else if (is_eret) begin
            m_status[1] = 1'b0;
            m_status[2] = 1'b0;
        end else if (wr_ok) begin
            if (wr_addr == 5'd12) m_status = (m_status & ~32'h0000_FF07) | (wr_data & 32'h0000_FF07);
            if (wr_addr == 5'd13) m_ipsw = wr_data[9:8];
            if (wr_addr == 5'd14) m_epc = wr_data;
        end
    endtask

    task automatic tick();
        predict_and_push();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t rd_addr=%0d actual=%h expected=%h", name, $time, mon_e.ra, act, exp_v);
        end
    endtask

    // Pop one prediction per cycle and compare away from the active edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("rd_data",        rd_data,                mon_e.rd);
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mon_e.rv});
            chk("redirect_pc",    redirect_pc,            mon_e.rpc);
            chk("status",         status,                 mon_e.st);
            chk("epc",            epc,                    mon_e.ep);
            chk("interrupt_info", {24'd0, interrupt_info}, {24'd0, mon_e.ii});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        reset = 1'b0; exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0;
        exc_in_delay_slot = 1'b0; exc_badvaddr = 32'd0; is_eret = 1'b0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; rd_addr = 5'd0;
    endtask

    task automatic rd(input logic [4:0] a);
        idle(); rd_addr = a; tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; rd_addr = a; tick();
    endtask

    task automatic exc(input logic [4:0] c, input logic [31:0] pc, input logic ds, input logic [31:0] bv);
        idle(); exc_valid = 1'b1; exc_code = c; exc_pc = pc; exc_in_delay_slot = ds;
        exc_badvaddr = bv; rd_addr = 5'd14; tick();
    endtask

    logic [4:0] codes [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    logic [4:0] addrs [8]  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};

    initial begin
        logic [4:0] rlist [7];
        rlist = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
        ext_int = 6'd0;
        idle();
        reset = 1'b1; tick();
        reset = 1'b1; tick();
        // reset values and Count start
        foreach (rlist[i]) rd(rlist[i]);
        // delay-slot address error, then register readback
        exc(5'd4, 32'h8000_1004, 1'b1, 32'h0000_0003);
        rd(5'd14); rd(5'd13); rd(5'd8); rd(5'd12);
        // nested syscall keeps EPC/BD/BadVAddr
        exc(5'd8, 32'h8000_2000, 1'b0, 32'hDEAD_BEEF);
        rd(5'd14); rd(5'd13); rd(5'd8);
        // ERET back to EPC
        idle(); is_eret = 1'b1; rd_addr = 5'd12; tick();
        rd(5'd12);
        // timer interrupt
        wr(5'd11, 32'd5);
        wr(5'd12, 32'h0000_8001);
        wr(5'd9, 32'd0);
        for (int i = 0; i < 14; i++) rd(5'd13);
        wr(5'd11, 32'd100);
        rd(5'd13); rd(5'd13);
        // same-cycle priority
        idle(); exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_3000;
        is_eret = 1'b1; wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'h0000_1234; rd_addr = 5'd14; tick();
        rd(5'd14);
        idle(); is_eret = 1'b1; wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'h0000_1234; rd_addr = 5'd14; tick();
        rd(5'd14);
        // interrupt routing through IM2
        wr(5'd12, 32'h0000_0401);
        ext_int = 6'b000001; rd(5'd13); rd(5'd13);
        ext_int = 6'b000000; rd(5'd13); rd(5'd13);
        // Count wrap with Compare at 0
        wr(5'd11, 32'd0);
        wr(5'd9, 32'hFFFF_FFFE);
        for (int i = 0; i < 6; i++) rd(5'd13);
        // randomized traffic
        for (int n = 0; n < 900; n++) begin
            idle();
            reset             = ($urandom_range(0, 199) == 0);
            exc_valid         = ($urandom_range(0, 9) == 0);
            exc_code          = codes[$urandom_range(0, 9)];
            exc_pc            = $urandom;
            exc_in_delay_slot = $urandom_range(0, 1) == 1;
            exc_badvaddr      = $urandom;
            is_eret           = ($urandom_range(0, 9) == 0);
            wr_en             = ($urandom_range(0, 3) == 0);
            wr_addr           = addrs[$urandom_range(0, 7)];
            case (wr_addr)
                5'd9:    wr_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFA : m_count + 32'($urandom_range(0, 3));
                5'd11:   wr_data = m_count + 32'($urandom_range(0, 12));
                default: wr_data = $urandom;
            endcase
            rd_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : addrs[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) ext_int = 6'($urandom);
            tick();
        end
        idle();
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
